// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the FPU-side sequencers.
//   fpu_op_e            - operation code presented to the FPU.
//   fpu_seq_state_e     - state encoding of the Horner polynomial sequencer.
//   FPU_SEQ_MAX_DEGREE  - highest polynomial degree the sequencer supports.
package ibex_pkg;

    typedef enum logic [1:0] {
        FPU_OP_ADD = 2'd0,
        FPU_OP_SUB = 2'd1,
        FPU_OP_MUL = 2'd2,
        FPU_OP_DIV = 2'd3
    } fpu_op_e;

    localparam int unsigned FPU_SEQ_MAX_DEGREE = 32'd7;

    typedef enum logic [2:0] {
        FPU_SEQ_IDLE = 3'd0,
        FPU_SEQ_LOAD = 3'd1,
        FPU_SEQ_MUL  = 3'd2,
        FPU_SEQ_ADD  = 3'd3,
        FPU_SEQ_DONE = 3'd4
    } fpu_seq_state_e;

endpackage

// File: rtl/ibex_fpu_horner_seq.sv
// ibex_fpu_horner_seq: evaluates p(x) = c_n*x^n + ... + c_0 with Horner's rule
// by sequencing multiply/add requests to an external FPU that is connected at
// the parent level.
//
// Ports:
//   clk_i, rst_i            - clock and synchronous active-high reset
//   start_i                 - start request, only looked at while idle
//   degree_i, x_i           - degree n (clamped to MaxDegree) and point x, captured on start
//   coef_valid_i/coef_ready_o/coef_i - coefficient stream, c_n first, c_0 last
//   fpu_en_o, fpu_operator_o, fpu_operand_a_o, fpu_operand_b_o - FPU request
//   fpu_result_i, fpu_valid_i, fpu_overflow_i, fpu_underflow_i, fpu_invalid_i - FPU response
//   busy_o, done_o          - activity and one-cycle completion pulse
//   result_o                - accumulator, holds p(x) from done until the next start
//   flags_o                 - {invalid, overflow, underflow}
//
// Build option: define IBEX_FPU_SEQ_FLAGS_EN to collect sticky FPU exception
// flags on flags_o; without it flags_o is constant zero.
module ibex_fpu_horner_seq
    import ibex_pkg::*;
#(
    parameter int unsigned DataWidth = 32'd32,
    parameter int unsigned MaxDegree = FPU_SEQ_MAX_DEGREE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [2:0]           degree_i,
    input  logic [DataWidth-1:0] x_i,
    input  logic                 coef_valid_i,
    output logic                 coef_ready_o,
    input  logic [DataWidth-1:0] coef_i,
    output logic                 fpu_en_o,
    output ibex_pkg::fpu_op_e    fpu_operator_o,
    output logic [DataWidth-1:0] fpu_operand_a_o,
    output logic [DataWidth-1:0] fpu_operand_b_o,
    input  logic [DataWidth-1:0] fpu_result_i,
    input  logic                 fpu_valid_i,
    input  logic                 fpu_overflow_i,
    input  logic                 fpu_underflow_i,
    input  logic                 fpu_invalid_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DataWidth-1:0] result_o,
    output logic [2:0]           flags_o
);

    // degree_i is 3 bits wide, so the cap only bites for MaxDegree < 7.
    localparam logic [2:0] DegreeCap = 3'(MaxDegree);

    fpu_seq_state_e       state_r;
    fpu_seq_state_e       state_next_s;
    logic [DataWidth-1:0] acc_r;
    logic [DataWidth-1:0] acc_next_s;
    logic [DataWidth-1:0] x_r;
    logic [2:0]           k_r;
    logic [2:0]           degree_clamped_s;
    logic                 start_accept_s;
    logic                 coef_fire_s;
    logic                 acc_load_s;
    logic                 k_dec_s;
    logic                 fpu_done_s;

    // Status outputs are pure decodes of the state register. Ready is masked
    // during reset so a coefficient offered in the reset cycle is never taken.
    assign busy_o         = (state_r != FPU_SEQ_IDLE);
    assign done_o         = (state_r == FPU_SEQ_DONE);
    assign coef_ready_o   = ((state_r == FPU_SEQ_LOAD) || (state_r == FPU_SEQ_ADD)) && !rst_i;
    assign coef_fire_s    = coef_valid_i && coef_ready_o;
    assign start_accept_s = (state_r == FPU_SEQ_IDLE) && start_i;
    assign result_o       = acc_r;

    // Clamp the requested degree to the supported maximum.
    always_comb begin
        degree_clamped_s = degree_i;
        if ({29'd0, degree_i} > MaxDegree) begin
            degree_clamped_s = DegreeCap;
        end else begin
            degree_clamped_s = degree_i;
        end
    end

    // Next state, accumulator update and the FPU request for the current state.
    always_comb begin
        state_next_s    = state_r;
        acc_next_s      = acc_r;
        acc_load_s      = 1'b0;
        k_dec_s         = 1'b0;
        fpu_done_s      = 1'b0;
        fpu_en_o        = 1'b0;
        fpu_operator_o  = FPU_OP_ADD;
        fpu_operand_a_o = {DataWidth{1'b0}};
        fpu_operand_b_o = {DataWidth{1'b0}};
        case (state_r)
            FPU_SEQ_IDLE: begin
                if (start_i) begin
                    state_next_s = FPU_SEQ_LOAD;
                end else begin
                    state_next_s = FPU_SEQ_IDLE;
                end
            end
            FPU_SEQ_LOAD: begin
                // Leading coefficient c_n seeds the accumulator.
                if (coef_fire_s) begin
                    acc_next_s = coef_i;
                    acc_load_s = 1'b1;
                    if (k_r == 3'd0) begin
                        state_next_s = FPU_SEQ_DONE;
                    end else begin
                        state_next_s = FPU_SEQ_MUL;
                    end
                end else begin
                    state_next_s = FPU_SEQ_LOAD;
                end
            end
            FPU_SEQ_MUL: begin
                fpu_en_o        = 1'b1;
                fpu_operator_o  = FPU_OP_MUL;
                fpu_operand_a_o = acc_r;
                fpu_operand_b_o = x_r;
                if (fpu_valid_i) begin
                    acc_next_s   = fpu_result_i;
                    acc_load_s   = 1'b1;
                    k_dec_s      = 1'b1;
                    fpu_done_s   = 1'b1;
                    state_next_s = FPU_SEQ_ADD;
                end else begin
                    state_next_s = FPU_SEQ_MUL;
                end
            end
            FPU_SEQ_ADD: begin
                // The add is only requested while a coefficient is offered; the
                // coefficient is consumed together with the FPU result, so the
                // source keeps it steady through any FPU stall.
                if (coef_valid_i) begin
                    fpu_en_o        = 1'b1;
                    fpu_operator_o  = FPU_OP_ADD;
                    fpu_operand_a_o = acc_r;
                    fpu_operand_b_o = coef_i;
                    if (fpu_valid_i && coef_fire_s) begin
                        acc_next_s = fpu_result_i;
                        acc_load_s = 1'b1;
                        fpu_done_s = 1'b1;
                        if (k_r == 3'd0) begin
                            state_next_s = FPU_SEQ_DONE;
                        end else begin
                            state_next_s = FPU_SEQ_MUL;
                        end
                    end else begin
                        state_next_s = FPU_SEQ_ADD;
                    end
                end else begin
                    state_next_s = FPU_SEQ_ADD;
                end
            end
            FPU_SEQ_DONE: begin
                state_next_s = FPU_SEQ_IDLE;
            end
            default: begin
                state_next_s = FPU_SEQ_IDLE;
            end
        endcase
    end

    // State, captured operands, remaining-degree counter and accumulator.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= FPU_SEQ_IDLE;
            acc_r   <= {DataWidth{1'b0}};
            x_r     <= {DataWidth{1'b0}};
            k_r     <= 3'd0;
        end else begin
            state_r <= state_next_s;
            if (start_accept_s) begin
                x_r <= x_i;
                k_r <= degree_clamped_s;
            end else if (k_dec_s) begin
                k_r <= k_r - 3'd1;
            end
            if (acc_load_s) begin
                acc_r <= acc_next_s;
            end
        end
    end

`ifdef IBEX_FPU_SEQ_FLAGS_EN
    logic [2:0] flags_r;

    // Sticky exception flags over every completed FPU operation of a run.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_r <= 3'b000;
        end else if (start_accept_s) begin
            flags_r <= 3'b000;
        end else if (fpu_done_s) begin
            flags_r <= flags_r | {fpu_invalid_i, fpu_overflow_i, fpu_underflow_i};
        end
    end

    assign flags_o = flags_r;
`else
    logic unused_flags_s;
    logic unused_fpu_done_s;

    assign unused_flags_s    = fpu_invalid_i ^ fpu_overflow_i ^ fpu_underflow_i;
    assign unused_fpu_done_s = fpu_done_s;
    assign flags_o           = 3'b000;
`endif

endmodule

// File: tb/tb_ibex_fpu_horner_seq.sv
// Self-checking bench for ibex_fpu_horner_seq. A behavioural single-precision
// FPU (real arithmetic, truncating, flush-to-zero) answers the DUT's requests
// with a programmable stall; random runs are checked against a direct integer
// sum c_k * x^k converted to single precision.
module tb_ibex_fpu_horner_seq;
    import ibex_pkg::*;

`ifdef IBEX_FPU_SEQ_FLAGS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  degree_i;
    logic [31:0] x_i;
    logic        coef_valid_i;
    logic        coef_ready_o;
    logic [31:0] coef_i;
    logic        fpu_en_o;
    fpu_op_e     fpu_operator_o;
    logic [31:0] fpu_operand_a_o;
    logic [31:0] fpu_operand_b_o;
    logic [31:0] fpu_result_i;
    logic        fpu_valid_i;
    logic        fpu_overflow_i;
    logic        fpu_underflow_i;
    logic        fpu_invalid_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [2:0]  flags_o;

    int checks = 0;
    int errors = 0;
    int stall_left = 0;
    logic [31:0] coef_q [8];
    int          gap_q  [8];
    logic [34:0] fpu_rsp;

    always #5 clk_i = ~clk_i;

    ibex_fpu_horner_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .degree_i(degree_i), .x_i(x_i),
        .coef_valid_i(coef_valid_i), .coef_ready_o(coef_ready_o), .coef_i(coef_i),
        .fpu_en_o(fpu_en_o), .fpu_operator_o(fpu_operator_o),
        .fpu_operand_a_o(fpu_operand_a_o), .fpu_operand_b_o(fpu_operand_b_o),
        .fpu_result_i(fpu_result_i), .fpu_valid_i(fpu_valid_i),
        .fpu_overflow_i(fpu_overflow_i), .fpu_underflow_i(fpu_underflow_i),
        .fpu_invalid_i(fpu_invalid_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .flags_o(flags_o)
    );

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    // Returns {invalid, overflow, underflow, bits}.
    function automatic logic [34:0] r2f(input real r);
        real  a;
        int   e;
        logic s;
        logic [22:0] man;
        if (r == 0.0) return 35'd0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0 && e < 200) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > -200) begin a = a * 2.0; e--; end
        if (e > 127) return {3'b010, s, 8'hFF, 23'd0};
        if (e < -126) return {3'b001, s, 31'd0};
        man = 23'($rtoi((a - 1.0) * 8388608.0));
        return {3'b000, s, 8'(e + 127), man};
    endfunction

    function automatic logic [34:0] fpu_model(input fpu_op_e op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic nan_a, nan_b, inf_a, inf_b;
        real  r;
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (nan_a || nan_b) return {3'b100, 32'h7FC00000};
        if (op == FPU_OP_MUL) begin
            if (inf_a || inf_b) return {3'b000, a[31] ^ b[31], 8'hFF, 23'd0};
            r = f2r(a) * f2r(b);
        end else begin
            if (inf_a && inf_b && (a[31] != b[31])) return {3'b100, 32'h7FC00000};
            if (inf_a) return {3'b000, a};
            if (inf_b) return {3'b000, b};
            r = f2r(a) + f2r(b);
        end
        return r2f(r);
    endfunction

    function automatic logic [31:0] int2f(input int v);
        logic [34:0] t;
        t = r2f(real'(v));
        return t[31:0];
    endfunction

    assign fpu_rsp      = fpu_model(fpu_operator_o, fpu_operand_a_o, fpu_operand_b_o);
    assign fpu_result_i = fpu_rsp[31:0];
    assign {fpu_invalid_i, fpu_overflow_i, fpu_underflow_i} = fpu_rsp[34:32];
    assign fpu_valid_i  = fpu_en_o && (stall_left == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Runs one evaluation from coef_q/gap_q; entered and left just after a rising edge.
    task automatic run_poly(input string tag, input logic [2:0] deg, input logic [31:0] x,
                            input logic stall_en, input logic [31:0] exp_res,
                            input logic [2:0] exp_flags, input int exp_cyc);
        int   cyc, idx, wait_cnt, done_cyc, en_cycles, en_in_gap;
        int   busy_bad, idle_bad, hold_bad, tail_bad;
        logic consumed, completed, en_s, ready_s, valid_s, prev_stall;
        fpu_op_e prev_op;
        logic [31:0] prev_a, prev_b;
        idx = 0; wait_cnt = gap_q[0]; done_cyc = -1; en_cycles = 0; en_in_gap = 0;
        busy_bad = 0; idle_bad = 0; hold_bad = 0; tail_bad = 0; prev_stall = 1'b0;
        prev_op = FPU_OP_ADD; prev_a = 32'd0; prev_b = 32'd0;
        start_i = 1'b1; degree_i = deg; x_i = x;
        coef_valid_i = (wait_cnt == 0); coef_i = coef_q[0];
        stall_left = stall_en ? int'($urandom_range(0, 2)) : 0;
        cyc = 0;
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge clk_i);
            if (busy_o !== (cyc != 0)) busy_bad++;
            if (fpu_en_o) en_cycles++;
            if (coef_ready_o && !coef_valid_i && fpu_en_o) en_in_gap++;
            if (!fpu_en_o && (fpu_operator_o !== FPU_OP_ADD || fpu_operand_a_o !== 32'd0 ||
                              fpu_operand_b_o !== 32'd0)) idle_bad++;
            if (prev_stall && (!fpu_en_o || fpu_operator_o !== prev_op ||
                               fpu_operand_a_o !== prev_a || fpu_operand_b_o !== prev_b)) hold_bad++;
            en_s = fpu_en_o; ready_s = coef_ready_o; valid_s = coef_valid_i;
            consumed  = coef_valid_i && coef_ready_o && (!fpu_en_o || fpu_valid_i);
            completed = fpu_en_o && fpu_valid_i;
            prev_stall = fpu_en_o && !fpu_valid_i;
            prev_op = fpu_operator_o; prev_a = fpu_operand_a_o; prev_b = fpu_operand_b_o;
            if (done_o) done_cyc = cyc;
            @(posedge clk_i); #1;
            cyc++;
            // Junk on start/degree/x while busy must be ignored.
            start_i  = (done_cyc < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            degree_i = 3'($urandom);
            x_i      = $urandom;
            if (consumed) begin
                idx++;
                wait_cnt = (idx <= int'(deg)) ? gap_q[idx] : 0;
            end else if (ready_s && !valid_s && wait_cnt > 0) begin
                wait_cnt--;
            end
            if (completed) stall_left = stall_en ? int'($urandom_range(0, 2)) : 0;
            else if (en_s && stall_left > 0) stall_left--;
            coef_valid_i = (wait_cnt == 0);
            coef_i = (idx <= int'(deg)) ? coef_q[idx] : 32'hDEADBEEF;
        end
        // Two idle cycles with a surplus coefficient offered.
        coef_valid_i = 1'b1; coef_i = 32'hDEADBEEF;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk_i);
            if (coef_ready_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) tail_bad++;
            if (result_o !== exp_res) tail_bad++;
            @(posedge clk_i); #1;
        end
        coef_valid_i = 1'b0;
        chk({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        if (exp_cyc >= 0) chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
        chk({tag, "_result"}, result_o, exp_res);
        chk({tag, "_flags"}, 32'(flags_o), 32'(exp_flags));
        chk({tag, "_coefs_taken"}, 32'(idx), 32'(deg) + 32'd1);
        if (!stall_en) chk({tag, "_fpu_en_cycles"}, 32'(en_cycles), 32'(deg) * 32'd2);
        chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
        chk({tag, "_idle_fpu_bus"}, 32'(idle_bad), 32'd0);
        chk({tag, "_stall_hold"}, 32'(hold_bad), 32'd0);
        chk({tag, "_en_in_gap"}, 32'(en_in_gap), 32'd0);
        chk({tag, "_after_done"}, 32'(tail_bad), 32'd0);
    endtask

    typedef struct packed {
        logic [2:0]       deg;
        logic [31:0]      x;
        logic [7:0][31:0] c;      // stream order: c[0] is c_n
        logic [7:0][3:0]  gap;
        logic [31:0]      res;
        logic [2:0]       flags;
        int               cyc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cint [8];
        int xv, deg, acc, pw;
        vecs[0] = '0; vecs[0].deg = 3'd2; vecs[0].x = 32'h40000000;
        vecs[0].c[0] = 32'h3F800000; vecs[0].c[1] = 32'h3F800000; vecs[0].c[2] = 32'h3F800000;
        vecs[0].res = 32'h40E00000; vecs[0].flags = 3'b000; vecs[0].cyc = 6;
        vecs[1] = '0; vecs[1].deg = 3'd0; vecs[1].x = 32'h12345678;
        vecs[1].c[0] = 32'h40400000; vecs[1].res = 32'h40400000; vecs[1].cyc = 2;
        vecs[2] = '0; vecs[2].deg = 3'd1; vecs[2].x = 32'h40400000;
        vecs[2].c[0] = 32'h3F800000; vecs[2].c[1] = 32'h3F800000; vecs[2].gap[1] = 4'd3;
        vecs[2].res = 32'h40800000; vecs[2].cyc = 7;
        vecs[3] = '0; vecs[3].deg = 3'd1; vecs[3].x = 32'h7FC00000;
        vecs[3].c[0] = 32'h3F800000; vecs[3].c[1] = 32'h3F800000;
        vecs[3].res = 32'h7FC00000; vecs[3].flags = FLAGS_ON ? 3'b100 : 3'b000; vecs[3].cyc = 4;
        vecs[4] = '0; vecs[4].deg = 3'd1; vecs[4].x = 32'h7F000000;
        vecs[4].c[0] = 32'h40800000; vecs[4].c[1] = 32'h00000000;
        vecs[4].res = 32'h7F800000; vecs[4].flags = FLAGS_ON ? 3'b010 : 3'b000; vecs[4].cyc = 4;
        vecs[5] = '0; vecs[5].deg = 3'd7; vecs[5].x = 32'h3F800000;
        for (int j = 0; j < 8; j++) vecs[5].c[j] = 32'h3F800000;
        vecs[5].res = 32'h41000000; vecs[5].cyc = 16;

        // Reset with a coefficient and a start offered.
        rst_i = 1'b1; start_i = 1'b1; degree_i = 3'd3; x_i = 32'h40000000;
        coef_valid_i = 1'b1; coef_i = 32'h3F800000;
        @(posedge clk_i); @(negedge clk_i);
        chk("reset_cycle_ready", 32'(coef_ready_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; start_i = 1'b0; coef_valid_i = 1'b0;
        @(negedge clk_i);
        chk("reset_outputs", {busy_o, done_o, coef_ready_o, fpu_en_o, flags_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        @(posedge clk_i); #1;

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 8; j++) begin
                coef_q[j] = vecs[i].c[j];
                gap_q[j]  = int'(vecs[i].gap[j]);
            end
            run_poly($sformatf("vec%0d", i), vecs[i].deg, vecs[i].x, 1'b0,
                     vecs[i].res, vecs[i].flags, vecs[i].cyc);
        end

        // Reset in the middle of a multiply that the FPU is stalling.
        coef_q[0] = 32'h3F800000;
        start_i = 1'b1; degree_i = 3'd3; x_i = 32'h40000000;
        coef_valid_i = 1'b1; coef_i = 32'h3F800000; stall_left = 100;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        coef_valid_i = 1'b0;
        @(negedge clk_i);
        chk("midrun_in_mul", 32'(fpu_en_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; stall_left = 0;
        @(negedge clk_i);
        chk("midrun_reset_state", {busy_o, fpu_en_o, done_o, coef_ready_o}, 32'd0);
        chk("midrun_reset_result", result_o, 32'd0);
        @(posedge clk_i); #1;
        coef_q[0] = 32'h40400000; gap_q[0] = 0;
        run_poly("after_reset", 3'd0, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 2);

        // Random polynomials with small integer values, FPU stalls and stream gaps.
        for (int r = 0; r < 15; r++) begin
            deg = int'($urandom_range(0, 7));
            xv  = int'($urandom_range(0, 6)) - 3;
            for (int k = 0; k < 8; k++) cint[k] = int'($urandom_range(0, 18)) - 9;
            acc = 0;
            pw  = 1;
            for (int k = 0; k <= deg; k++) begin
                acc = acc + cint[k] * pw;
                pw  = pw * xv;
            end
            for (int j = 0; j < 8; j++) begin
                coef_q[j] = (j <= deg) ? int2f(cint[deg - j]) : 32'd0;
                gap_q[j]  = int'($urandom_range(0, 2));
            end
            run_poly($sformatf("rand%0d", r), 3'(deg), int2f(xv), 1'b1, int2f(acc), 3'b000, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
